// File: rtl/rx_frame_controller.sv
// rx_frame_controller: start-bit detection, per-bit sample timing and
// stop-bit validation for the serial receive path. The shift register
// itself is outside this block; it is driven through shift_en/shift_bit.
//
// state | meaning
// IDLE  | waiting for a falling line while armed and enabled
// START | timing the start bit, rejecting it if high at the sample point
// DATA  | timing data bits, one shift strobe per bit
// STOP  | timing the stop bit, exits early at its sample point
// BREAK | stop bit was low; wait for the line to return high
module rx_frame_controller #(
  parameter int OVERSAMPLE   = 16,
  parameter int SAMPLE_POINT = 7,
  parameter int DATA_BITS    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       rx_in,
  output logic       shift_en,
  output logic       shift_bit,
  output logic [3:0] bit_index,
  output logic       char_valid,
  output logic       frame_error,
  output logic       false_start,
  output logic       busy
);

  localparam int SUB_W = $clog2(OVERSAMPLE);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(OVERSAMPLE - 1);
  localparam logic [SUB_W-1:0] SUB_SAMP = SUB_W'(SAMPLE_POINT);
  localparam logic [3:0]       BIT_LAST = 4'(DATA_BITS - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  logic [2:0]       state, state_n;
  logic [SUB_W-1:0] sub_cnt, sub_n, sub_inc;
  logic [3:0]       bit_cnt, bit_n;
  logic             armed, armed_n;
  logic             shift_en_n, shift_bit_n;
  logic             char_valid_n, frame_error_n, false_start_n;
  logic             at_samp, at_last;

  assign sub_inc = (sub_cnt == SUB_LAST) ? '0 : sub_cnt + SUB_W'(1);
  assign at_samp = (sub_cnt == SUB_SAMP);
  assign at_last = (sub_cnt == SUB_LAST);

  // Next-state, counter and pulse decode for the receive sequence.
  always_comb begin
    state_n       = state;
    sub_n         = sub_cnt;
    bit_n         = bit_cnt;
    armed_n       = armed;
    shift_en_n    = 1'b0;
    shift_bit_n   = shift_bit;
    char_valid_n  = 1'b0;
    frame_error_n = 1'b0;
    false_start_n = 1'b0;
    case (state)
      ST_IDLE: begin
        // A line that has never been seen high since reset/break is not a start.
        if (rx_in) begin
          armed_n = 1'b1;
        end else if (enable && armed) begin
          state_n = ST_START;
          sub_n   = '0;
        end
      end
      ST_START: begin
        sub_n = sub_inc;
        if (at_samp && rx_in) begin
          false_start_n = 1'b1;
          state_n       = ST_IDLE;
          sub_n         = '0;
        end else if (at_last) begin
          bit_n   = '0;
          state_n = ST_DATA;
        end
      end
      ST_DATA: begin
        sub_n = sub_inc;
        if (at_samp) begin
          shift_en_n  = 1'b1;
          shift_bit_n = rx_in;
        end
        if (at_last) begin
          if (bit_cnt == BIT_LAST) state_n = ST_STOP;
          else                     bit_n   = bit_cnt + 4'd1;
        end
      end
      ST_STOP: begin
        sub_n = sub_inc;
        // Leave at the sample point so the next start edge can land inside
        // the remainder of this stop bit.
        if (at_samp) begin
          sub_n = '0;
          if (rx_in) begin
            char_valid_n = 1'b1;
            state_n      = ST_IDLE;
          end else begin
            frame_error_n = 1'b1;
            state_n       = ST_BREAK;
            armed_n       = 1'b0;
          end
        end
      end
      ST_BREAK: begin
        if (rx_in) begin
          armed_n = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
        sub_n   = '0;
      end
    endcase
  end

  // State, counters and registered outputs; outputs are decoded from next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      sub_cnt     <= '0;
      bit_cnt     <= '0;
      armed       <= 1'b0;
      shift_en    <= 1'b0;
      shift_bit   <= 1'b0;
      bit_index   <= '0;
      char_valid  <= 1'b0;
      frame_error <= 1'b0;
      false_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      sub_cnt     <= sub_n;
      bit_cnt     <= bit_n;
      armed       <= armed_n;
      shift_en    <= shift_en_n;
      shift_bit   <= shift_bit_n;
      bit_index   <= (state_n == ST_DATA) ? bit_n : 4'd0;
      char_valid  <= char_valid_n;
      frame_error <= frame_error_n;
      false_start <= false_start_n;
      busy        <= (state_n == ST_START) || (state_n == ST_DATA) ||
                     (state_n == ST_STOP);
    end
  end

endmodule
